text_pixel_renderer: RTL

- Pixel-side consumer of the AXI VRAM register file: converts the VGA scan position into a VRAM word select and reads the returned 32-bit word.
- Extracts one character byte, looks up the glyph row in an external synchronous font ROM, and emits 4-bit RGB.
- Text grid is 80x30 cells of 8x16 pixels; 4 characters per VRAM word (600 words).
- Colours come from control_reg.
- Sits between vga_controller/VRAM register file and the HDMI/TMDS encoder.

---
 rtl/text_pixel_renderer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/text_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module  : text_pixel_renderer
// Brief   : 80x30 text-mode pixel pipeline (VRAM word -> font ROM -> RGB),
//           fixed 4-cycle latency. Optional blink: define TEXT_BLINK_EN.
// Rev     : 1.0
// ============================================================================
module text_pixel_renderer #(
  parameter int H_CHARS    = 80,
  parameter int V_CHARS    = 30,
  parameter int VRAM_WORDS = 600,
  parameter int BLINK_BIT  = 5
) (
  input  logic        pixel_clk,
  input  logic        reset_ah,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        vde,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  vram_word_select,
  input  logic [31:0] vram_data_out,
  input  logic [31:0] control_reg,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out
);

  localparam logic [11:0] H_CHARS_W  = 12'(H_CHARS);
  localparam logic [9:0]  X_LIMIT    = 10'(H_CHARS * 8);
  localparam logic [9:0]  Y_LIMIT    = 10'(V_CHARS * 16);
  localparam logic [9:0]  WORD_LIMIT = 10'(VRAM_WORDS);
  localparam logic [2:0]  SYNC_IDLE  = 3'b110; // {hsync, vsync, vde}

  logic [9:0]  word_sel_q, word_sel_d;
  logic [1:0]  byte_sel_q, byte_sel_d;
  logic [3:0]  grow_q, grow_d;
  logic [2:0]  bit1_q, bit1_d, bit2_q, bit2_d, bit3_q, bit3_d;
  logic        vis1_q, vis1_d, vis2_q, vis2_d, vis3_q, vis3_d;
  logic        inv2_q, inv2_d, inv3_q, inv3_d;
  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, sync4_q, sync4_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic [11:0] rgb_q, rgb_d;

  logic [11:0] idx;
  logic        in_range;
  logic [7:0]  vram_byte;
  logic        pix;

`ifdef TEXT_BLINK_EN
  logic        vs_prev_q, vs_prev_d;
  logic [7:0]  frame_q, frame_d;
`endif

  always_comb begin
    // S1: scan position -> cell index; vis doubles as the blank flag (0 = black)
    idx        = 12'(drawY[9:4]) * H_CHARS_W + 12'(drawX[9:3]);
    in_range   = vde && (drawX < X_LIMIT) && (drawY < Y_LIMIT) && (idx[11:2] < WORD_LIMIT);
    word_sel_d = in_range ? idx[11:2] : word_sel_q;
    byte_sel_d = idx[1:0];
    grow_d     = drawY[3:0];
    bit1_d     = drawX[2:0];
    vis1_d     = in_range;
    sync1_d    = {hsync_in, vsync_in, vde};

    // S2: byte 0 is the leftmost cell of the word
    vram_byte   = vram_data_out[{byte_sel_q, 3'b000} +: 8];
    font_addr_d = {vram_byte[6:0], grow_q};
    inv2_d      = vram_byte[7];
    bit2_d      = bit1_q;
    vis2_d      = vis1_q;
    sync2_d     = sync1_q;

    // S3: external ROM registers font_data alongside these
    inv3_d  = inv2_q;
    bit3_d  = bit2_q;
    vis3_d  = vis2_q;
    sync3_d = sync2_q;

    // S4
    pix = font_data[3'd7 - bit3_q] ^ inv3_q;
`ifdef TEXT_BLINK_EN
    vs_prev_d = vsync_in;
    frame_d   = (vs_prev_q && !vsync_in) ? frame_q + 8'd1 : frame_q;
    if (control_reg[0] && frame_q[BLINK_BIT] && inv3_q) begin
      pix = 1'b0;
    end
`endif
    rgb_d   = !vis3_q ? 12'h000 : (pix ? control_reg[24:13] : control_reg[12:1]);
    sync4_d = sync3_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset_ah) begin
      word_sel_q  <= '0;
      byte_sel_q  <= '0;
      grow_q      <= '0;
      bit1_q      <= '0;
      bit2_q      <= '0;
      bit3_q      <= '0;
      vis1_q      <= 1'b0;
      vis2_q      <= 1'b0;
      vis3_q      <= 1'b0;
      inv2_q      <= 1'b0;
      inv3_q      <= 1'b0;
      sync1_q     <= SYNC_IDLE;
      sync2_q     <= SYNC_IDLE;
      sync3_q     <= SYNC_IDLE;
      sync4_q     <= SYNC_IDLE;
      font_addr_q <= '0;
      rgb_q       <= '0;
`ifdef TEXT_BLINK_EN
      vs_prev_q   <= 1'b1;
      frame_q     <= '0;
`endif
    end else begin
      word_sel_q  <= word_sel_d;
      byte_sel_q  <= byte_sel_d;
      grow_q      <= grow_d;
      bit1_q      <= bit1_d;
      bit2_q      <= bit2_d;
      bit3_q      <= bit3_d;
      vis1_q      <= vis1_d;
      vis2_q      <= vis2_d;
      vis3_q      <= vis3_d;
      inv2_q      <= inv2_d;
      inv3_q      <= inv3_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      sync4_q     <= sync4_d;
      font_addr_q <= font_addr_d;
      rgb_q       <= rgb_d;
`ifdef TEXT_BLINK_EN
      vs_prev_q   <= vs_prev_d;
      frame_q     <= frame_d;
`endif
    end
  end

  assign vram_word_select = word_sel_q;
  assign font_addr        = font_addr_q;
  assign red              = rgb_q[11:8];
  assign green            = rgb_q[7:4];
  assign blue             = rgb_q[3:0];
  assign hsync_out        = sync4_q[2];
  assign vsync_out        = sync4_q[1];
  assign vde_out          = sync4_q[0];

  // Reserved control bits (and the blink bit when blink is compiled out)
  logic unused_cfg;
  assign unused_cfg = ^{control_reg[31:25], control_reg[0], 32'(BLINK_BIT)};

endmodule
`default_nettype wire
